// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: widths, flag bit positions, opcodes, FSM states.
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU; flags are {overflow, neg, zero, carry}, carry is borrow for SUB.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   sel,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags
);
  logic [DATA_W:0]        wide;
  logic signed [DATA_W:0] swide;
  logic                   carry;
  logic                   ovf;

  always_comb begin
    wide   = '0;
    swide  = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (sel)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        swide  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = swide[DATA_W] ^ swide[DATA_W-1];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        swide  = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = swide[DATA_W] ^ swide[DATA_W-1];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_V] = ovf;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one alu_8bit: accept -> execute -> hold response until taken.
// Define ALU_ARB_ACC_EN to give each requester an accumulator usable as operand A.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [OP_W-1:0]     req0_sel,
  input  logic                req0_acc,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [OP_W-1:0]     req1_sel,
  input  logic                req1_acc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags
);
  state_t              state;
  state_t              state_next;
  logic                ptr;
  logic                gnt_id;
  logic                gnt_any;
  logic                accept;
  logic [DATA_W-1:0]   a0_eff;
  logic [DATA_W-1:0]   a1_eff;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [OP_W-1:0]     op_sel;
  logic                op_id;
  logic [DATA_W-1:0]   alu_result;
  logic [FLAG_W-1:0]   alu_flags;

  // Grant: a lone requester always wins; on contention the pointer (or requester 0) decides.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = !req0_valid;
    if (req0_valid && req1_valid)
      gnt_id = (RR != 0) ? ptr : 1'b0;
  end

  assign accept     = (state == ST_IDLE) && gnt_any && !rst;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign rsp_valid  = (state == ST_RESP);

`ifdef ALU_ARB_ACC_EN
  logic [DATA_W-1:0] acc0;
  logic [DATA_W-1:0] acc1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id) acc1 <= rsp_result;
      else        acc0 <= rsp_result;
    end
  end

  assign a0_eff = req0_acc ? acc0 : req0_a;
  assign a1_eff = req1_acc ? acc1 : req1_a;
`else
  logic unused_acc;
  assign unused_acc = req0_acc ^ req1_acc;
  assign a0_eff     = req0_a;
  assign a1_eff     = req1_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (gnt_any)   state_next = ST_EXEC;
      ST_EXEC:                state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Operand capture happens only in the accept cycle, so later input changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      op_id  <= 1'b0;
    end else if (accept) begin
      ptr    <= ~gnt_id;
      op_a   <= gnt_id ? a1_eff : a0_eff;
      op_b   <= gnt_id ? req1_b : req0_b;
      op_sel <= gnt_id ? req1_sel : req0_sel;
      op_id  <= gnt_id;
    end
  end

  alu_8bit u_alu (
    .a      (op_a),
    .b      (op_b),
    .sel    (op_sel),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (state == ST_EXEC) begin
      rsp_id     <= op_id;
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
    end
  end
endmodule
